// File: rtl/pps_pkg.sv
// Shared defaults, stage control struct and the lane adder for pps_pipe.
// Define PPS_SAT_EN to make every add saturate at 2^w-1 instead of wrapping modulo 2^w.
package pps_pkg;

    localparam int unsigned DefNW = 5;
    localparam int unsigned DefIW = 4;
    localparam int unsigned DefOW = 10;
    localparam int unsigned MaxW  = 32;

    typedef logic [DefIW-1:0] in_lane_t;
    typedef logic [DefOW-1:0] out_lane_t;
    typedef in_lane_t  in_lane_arr_t  [1 << DefNW];
    typedef out_lane_t out_lane_arr_t [1 << DefNW];

    typedef struct packed {
        logic valid;
        logic excl;
        logic last;
    } stage_ctl_t;

    // Operands are assumed already below 2^w; result is limited to w bits.
    function automatic logic [MaxW-1:0] pps_add(input logic [MaxW-1:0] a,
                                                input logic [MaxW-1:0] b,
                                                input int unsigned     w);
        logic [MaxW:0] one;
        logic [MaxW:0] lim;
        logic [MaxW:0] sum;
        one = {{MaxW{1'b0}}, 1'b1};
        lim = (one << w) - one;
        sum = {1'b0, a} + {1'b0, b};
`ifdef PPS_SAT_EN
        if (sum > lim) begin
            sum = lim;
        end
`endif
        return MaxW'(sum & lim);
    endfunction

endpackage

// File: rtl/pps_stage.sv
// One Kogge-Stone level of pps_pipe: lane i adds lane i-2^J, then registers lanes and control.
// Adder behaviour (wrap or saturate) follows PPS_SAT_EN through pps_pkg::pps_add.
module pps_stage
    import pps_pkg::*;
#(
    parameter int unsigned NW = DefNW,
    parameter int unsigned OW = DefOW,
    parameter int unsigned J  = 0,
    localparam int unsigned N = 1 << NW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic [OW-1:0] i_lane [N],
    input  logic          i_valid,
    input  logic          i_excl,
    input  logic          i_last,
    output logic [OW-1:0] o_lane [N],
    output logic          o_valid,
    output logic          o_excl,
    output logic          o_last
);

    localparam int unsigned Dist = 1 << J;

    logic [OW-1:0] w_sum [N];
    logic [OW-1:0] r_lane [N];
    stage_ctl_t    r_ctl;

    for (genvar i = 0; i < N; i++) begin : g_lane
        if (i < Dist) begin : g_pass
            assign w_sum[i] = i_lane[i];
        end else begin : g_add
            assign w_sum[i] = OW'(pps_add(MaxW'(i_lane[i]), MaxW'(i_lane[i - Dist]), OW));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctl <= '0;
            for (int i = 0; i < N; i++) begin
                r_lane[i] <= '0;
            end
        end else if (i_en) begin
            r_ctl <= '{valid: i_valid, excl: i_excl, last: i_last};
            for (int i = 0; i < N; i++) begin
                r_lane[i] <= w_sum[i];
            end
        end
    end

    assign o_lane  = r_lane;
    assign o_valid = r_ctl.valid;
    assign o_excl  = r_ctl.excl;
    assign o_last  = r_ctl.last;

endmodule

// File: rtl/pps_pipe.sv
// Pipelined streaming Kogge-Stone prefix scan with inclusive/exclusive mode and carry across beats.
// Optional PPS_SAT_EN: all tree and carry adds saturate at 2^OW-1 instead of wrapping.
module pps_pipe
    import pps_pkg::*;
#(
    parameter int unsigned NW = DefNW,
    parameter int unsigned IW = DefIW,
    parameter int unsigned OW = DefOW,
    localparam int unsigned N = 1 << NW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_data [N],
    input  logic          in_excl,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_psum [N],
    output logic [OW-1:0] out_total,
    output logic          out_last
);

    if (OW < IW + NW) begin : g_bad_ow
        $error("pps_pipe: OW must be at least IW+NW");
    end
    if (OW > MaxW) begin : g_wide_ow
        $error("pps_pipe: OW exceeds pps_pkg::MaxW");
    end

    logic          w_en;
    logic [OW-1:0] w_lane [NW+1][N];
    logic [NW:0]   w_valid;
    logic [NW:0]   w_excl;
    logic [NW:0]   w_last;
    logic [OW-1:0] w_psum [N];
    logic [OW-1:0] w_total;

    logic [OW-1:0] r_s0_lane [N];
    stage_ctl_t    r_s0_ctl;
    logic [OW-1:0] r_carry;
    logic [OW-1:0] r_psum [N];
    logic [OW-1:0] r_total;
    logic          r_out_valid;
    logic          r_out_last;

    // Single global enable: the whole pipe, bubbles included, moves or holds together.
    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_ctl <= '0;
            for (int i = 0; i < N; i++) begin
                r_s0_lane[i] <= '0;
            end
        end else if (w_en) begin
            r_s0_ctl <= '{valid: in_valid, excl: in_excl, last: in_last};
            for (int i = 0; i < N; i++) begin
                r_s0_lane[i] <= OW'(in_data[i]);
            end
        end
    end

    assign w_lane[0]  = r_s0_lane;
    assign w_valid[0] = r_s0_ctl.valid;
    assign w_excl[0]  = r_s0_ctl.excl;
    assign w_last[0]  = r_s0_ctl.last;

    for (genvar j = 0; j < NW; j++) begin : g_level
        pps_stage #(
            .NW(NW),
            .OW(OW),
            .J (j)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_en),
            .i_lane (w_lane[j]),
            .i_valid(w_valid[j]),
            .i_excl (w_excl[j]),
            .i_last (w_last[j]),
            .o_lane (w_lane[j+1]),
            .o_valid(w_valid[j+1]),
            .o_excl (w_excl[j+1]),
            .o_last (w_last[j+1])
        );
    end

    // Exclusive mode shifts the inclusive scan right by one lane and seeds lane 0 with the carry.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_psum[k] = OW'(pps_add(MaxW'(w_lane[NW][k]), MaxW'(r_carry), OW));
        end
        if (w_excl[NW]) begin
            w_psum[0] = r_carry;
            for (int k = 1; k < N; k++) begin
                w_psum[k] = OW'(pps_add(MaxW'(w_lane[NW][k-1]), MaxW'(r_carry), OW));
            end
        end
        w_total = OW'(pps_add(MaxW'(w_lane[NW][N-1]), MaxW'(r_carry), OW));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_total     <= '0;
            r_carry     <= '0;
            for (int k = 0; k < N; k++) begin
                r_psum[k] <= '0;
            end
        end else if (w_en) begin
            r_out_valid <= w_valid[NW];
            if (w_valid[NW]) begin
                r_out_last <= w_last[NW];
                r_total    <= w_total;
                r_carry    <= w_last[NW] ? '0 : w_total;
                for (int k = 0; k < N; k++) begin
                    r_psum[k] <= w_psum[k];
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_psum  = r_psum;
    assign out_total = r_total;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_pps_pipe.sv
// Bench for pps_pipe at NW=2, IW=4, OW=8: literal vector table plus scoreboarded sequences for
// latency, back-to-back segments, backpressure and mid-stream reset. Honours PPS_SAT_EN.
module tb_pps_pipe;

    localparam int unsigned NW = 2;
    localparam int unsigned IW = 4;
    localparam int unsigned OW = 8;
    localparam int unsigned N  = 4;
    localparam int          Max = 255;
    localparam int          NVec = 13;

    typedef struct {
        logic [IW-1:0] d [N];
        bit            excl;
        bit            last;
        logic [OW-1:0] psum [N];
        logic [OW-1:0] total;
    } vec_t;

    typedef struct {
        logic [OW-1:0] psum [N];
        logic [OW-1:0] total;
        bit            last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_data [N];
    logic          in_excl = 1'b0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] out_psum [N];
    logic [OW-1:0] out_total;
    logic          out_last;

    int   checks = 0;
    int   failures = 0;
    int   m_carry = 0;
    int   out_idx = 0;
    exp_t exp_q [$];
    exp_t cur_exp;
    exp_t mon_e;

    pps_pipe #(
        .NW(NW),
        .IW(IW),
        .OW(OW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_excl  (in_excl),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_psum (out_psum),
        .out_total(out_total),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int fold(input int x);
`ifdef PPS_SAT_EN
        return (x > Max) ? Max : x;
`else
        return x & Max;
`endif
    endfunction

    // Serial reference scan; with non-negative operands min(sum,Max) is association-independent.
    function automatic exp_t model(input logic [IW-1:0] d [N], input bit excl, input bit last,
                                   input int c);
        exp_t e;
        int   p [N];
        int   acc;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            acc += int'(d[i]);
            p[i] = acc;
        end
        for (int k = 0; k < N; k++) begin
            if (!excl)       e.psum[k] = OW'(fold(p[k] + c));
            else if (k == 0) e.psum[k] = OW'(c);
            else             e.psum[k] = OW'(fold(p[k-1] + c));
        end
        e.total = OW'(fold(p[N-1] + c));
        e.last  = last;
        return e;
    endfunction

    function automatic vec_t mk(input int d0, input int d1, input int d2, input int d3,
                                input bit excl, input bit last,
                                input int p0, input int p1, input int p2, input int p3,
                                input int t);
        vec_t v;
        v.d[0] = IW'(d0); v.d[1] = IW'(d1); v.d[2] = IW'(d2); v.d[3] = IW'(d3);
        v.excl = excl;
        v.last = last;
        v.psum[0] = OW'(p0); v.psum[1] = OW'(p1); v.psum[2] = OW'(p2); v.psum[3] = OW'(p3);
        v.total = OW'(t);
        return v;
    endfunction

    task automatic drive(input logic [IW-1:0] d [N], input bit excl, input bit last,
                         input exp_t e);
        bit   acc;
        exp_t me;
        me = model(d, excl, last, m_carry);
        m_carry = last ? 0 : int'(me.total);
        cur_exp  = e;
        in_data  = d;
        in_excl  = excl;
        in_last  = last;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        chk("beat_accepted", int'(acc), 1);
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [IW-1:0] d [N], input bit excl, input bit last);
        drive(d, excl, last, model(d, excl, last, m_carry));
    endtask

    task automatic send_vec(input vec_t v);
        exp_t e;
        e.psum  = v.psum;
        e.total = v.total;
        e.last  = v.last;
        drive(v.d, v.excl, v.last, e);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_total"}, int'(out_total), 0);
        chk({tag, "_out_last"}, int'(out_last), 0);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_out_psum[%0d]", tag, k), int'(out_psum[k]), 0);
        end
    endtask

    // Scoreboard: push on accepted input, pop and compare on accepted output.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("out%0d_expected_pending", out_idx), exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    for (int k = 0; k < N; k++) begin
                        chk($sformatf("out%0d_psum[%0d]", out_idx, k), int'(out_psum[k]),
                            int'(mon_e.psum[k]));
                    end
                    chk($sformatf("out%0d_total", out_idx), int'(out_total), int'(mon_e.total));
                    chk($sformatf("out%0d_last", out_idx), int'(out_last), int'(mon_e.last));
                end
                out_idx++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_exp);
            end
        end
    end

    initial begin
        vec_t          tbl [NVec];
        logic [IW-1:0] d [N];
        logic [OW-1:0] hold_psum [N];
        logic [OW-1:0] hold_total;
        int            lat;
        int            first_c;
        int            last_c;
        int            seen;
        int            n;

        tbl[0]  = mk(1, 2, 3, 4, 1'b0, 1'b1, 1, 3, 6, 10, 10);
        tbl[1]  = mk(1, 2, 3, 4, 1'b1, 1'b1, 0, 1, 3, 6, 10);
        tbl[2]  = mk(1, 2, 3, 4, 1'b0, 1'b0, 1, 3, 6, 10, 10);
        tbl[3]  = mk(1, 1, 1, 1, 1'b0, 1'b1, 11, 12, 13, 14, 14);
        tbl[4]  = mk(1, 1, 1, 1, 1'b0, 1'b1, 1, 2, 3, 4, 4);
        tbl[5]  = mk(15, 15, 15, 15, 1'b0, 1'b0, 15, 30, 45, 60, 60);
        tbl[6]  = mk(15, 15, 15, 15, 1'b0, 1'b0, 75, 90, 105, 120, 120);
        tbl[7]  = mk(15, 15, 15, 15, 1'b0, 1'b0, 135, 150, 165, 180, 180);
        tbl[8]  = mk(15, 15, 15, 15, 1'b0, 1'b0, 195, 210, 225, 240, 240);
`ifdef PPS_SAT_EN
        tbl[9]  = mk(15, 15, 15, 15, 1'b0, 1'b0, 255, 255, 255, 255, 255);
        tbl[10] = mk(2, 0, 5, 1, 1'b1, 1'b1, 255, 255, 255, 255, 255);
`else
        tbl[9]  = mk(15, 15, 15, 15, 1'b0, 1'b0, 255, 14, 29, 44, 44);
        tbl[10] = mk(2, 0, 5, 1, 1'b1, 1'b1, 44, 46, 46, 51, 52);
`endif
        tbl[11] = mk(0, 0, 0, 0, 1'b1, 1'b0, 0, 0, 0, 0, 0);
        tbl[12] = mk(15, 0, 0, 15, 1'b0, 1'b1, 15, 15, 15, 30, 30);

        for (int i = 0; i < N; i++) in_data[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_cleared("reset");

        // First-beat latency: accept edge to out_valid.
        send_vec(tbl[0]);
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency_cycles", lat, 3);
        wait_drain();

        // Whole table back-to-back; outputs must come out as one unbroken run.
        first_c = -1;
        last_c  = -1;
        seen    = 0;
        fork
            begin
                for (int i = 0; i < NVec; i++) send_vec(tbl[i]);
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen++;
                        if (first_c < 0) first_c = c;
                        last_c = c;
                    end
                end
            end
        join
        chk("table_out_count", seen, NVec);
        chk("table_out_contiguous", last_c - first_c + 1, NVec);
        wait_drain();

        // Backpressure: hold out_ready low for three cycles once outputs start.
        n = 0;
        fork
            begin
                for (int b = 0; b < 6; b++) begin
                    for (int i = 0; i < N; i++) d[i] = IW'($urandom_range(0, 15));
                    send_model(d, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
                end
            end
            begin
                while (!out_valid && n < 20) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk("bp_out_valid_seen", int'(out_valid), 1);
                out_ready  = 1'b0;
                hold_psum  = out_psum;
                hold_total = out_total;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk($sformatf("bp_in_ready_stall%0d", s), int'(in_ready), 0);
                    chk($sformatf("bp_out_valid_stall%0d", s), int'(out_valid), 1);
                    chk($sformatf("bp_total_held%0d", s), int'(out_total), int'(hold_total));
                    for (int k = 0; k < N; k++) begin
                        chk($sformatf("bp_psum_held%0d[%0d]", s, k), int'(out_psum[k]),
                            int'(hold_psum[k]));
                    end
                    @(posedge clk);
                end
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Mid-stream reset: carry 20 in place, two beats in flight.
        for (int i = 0; i < N; i++) d[i] = IW'(5);
        send_model(d, 1'b0, 1'b0);
        wait_drain();
        for (int i = 0; i < N; i++) d[i] = IW'(2);
        send_model(d, 1'b0, 1'b0);
        send_model(d, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_carry = 0;
        chk_cleared("midrst");
        send_vec(mk(1, 1, 1, 1, 1'b0, 1'b1, 1, 2, 3, 4, 4));
        wait_drain();
        repeat (8) @(posedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
